// File: rtl/uart_tx_core_if.sv
// rtl/uart_tx_core_if.sv - byte-side handshake between producer and uart_tx_core
interface uart_tx_core_if;
    logic       tx_trig;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output tx_trig,
        output tx_data,
        input  tx_busy
    );

    modport slave (
        input  tx_trig,
        input  tx_data,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter, 8N1 LSB first; PARITY_EN adds an even-parity bit (8E1)
module uart_tx_core #(
    parameter int BAUD_DIV = 10416
) (
    input  logic          s_clk,
    input  logic          s_rst,
    uart_tx_core_if.slave bus,
    output logic          rs232_tx
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          line_q, line_d;
    logic          busy_q, busy_d;
    logic          bit_end;
    logic [2:0]    idx_nxt;

`ifdef PARITY_EN
    logic          parity_bit;

    // Even parity: the transmitted parity bit makes the total count of ones even.
    assign parity_bit = ^data_q;
`endif

    assign bit_end  = (cnt_q == CNT_LAST);
    assign idx_nxt  = idx_q + 3'd1;
    assign rs232_tx = line_q;
    assign bus.tx_busy = busy_q;

    // Next-state logic; the line and busy values are computed for the next
    // state so that both outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        line_d  = line_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                line_d = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = 3'd0;
                if (bus.tx_trig) begin
                    // Data is captured here; later tx_data changes cannot reach the frame.
                    data_d  = bus.tx_data;
                    busy_d  = 1'b1;
                    line_d  = 1'b0;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    line_d  = data_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef PARITY_EN
                        line_d  = parity_bit;
                        state_d = ST_PARITY;
`else
                        line_d  = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d  = idx_nxt;
                        line_d = data_q[idx_nxt];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

`ifdef PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    line_d  = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif

            ST_STOP: begin
                // A trigger in the final stop cycle is not looked at: only
                // IDLE accepts triggers, which yields the one idle cycle gap.
                if (bit_end) begin
                    cnt_d   = '0;
                    line_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                idx_d   = 3'd0;
                line_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line high.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - scoreboard bench for uart_tx_core with a reference receiver
module tb_uart_tx_core;

    localparam int BD = 16;
`ifdef PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * BD;

    logic clk = 1'b0;
    logic s_rst;
    logic line;

    uart_tx_core_if bus();

    uart_tx_core #(.BAUD_DIV(BD)) dut (
        .s_clk    (clk),
        .s_rst    (s_rst),
        .bus      (bus),
        .rs232_tx (line)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.tx_busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        wait_idle();
        exp_q.push_back(b);
        bus.tx_trig = 1'b1;
        bus.tx_data = b;
        tick();
        bus.tx_trig = 1'b0;
        bus.tx_data = 8'($urandom);
        check("latency_line", 32'(line), 32'd0);
        check("latency_busy", 32'(bus.tx_busy), 32'd1);
    endtask

    // Reference receiver: detects the start edge, checks every cycle of the
    // frame against the expected bit pattern and decodes at mid-bit.
    logic        prev_line = 1'b1;
    logic        prev_busy = 1'b0;
    int          busy_cnt  = 0;
    logic        rx_active = 1'b0;
    logic        have_exp  = 1'b0;
    int          rx_cnt    = 0;
    int          shape_err = 0;
    logic [7:0]  exp_byte;
    logic [15:0] exp_bits;
    logic [15:0] sampled;

    always @(negedge clk) begin
        if (s_rst === 1'b1) begin
            if (rx_active && have_exp && exp_q.size() > 0) void'(exp_q.pop_front());
            rx_active = 1'b0;
            busy_cnt  = 0;
            prev_line = 1'b1;
            prev_busy = 1'b0;
        end else begin
            if (bus.tx_busy === 1'b1) begin
                busy_cnt++;
            end else if (prev_busy) begin
                check("busy_cycles", 32'(busy_cnt), 32'(FRAME));
                busy_cnt = 0;
            end
            prev_busy = bus.tx_busy;

            if (!rx_active) begin
                if (prev_line === 1'b1 && line === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    shape_err = 0;
                    sampled   = '0;
                    have_exp  = (exp_q.size() > 0);
                    if (!have_exp) check("unexpected_frame", 32'd1, 32'd0);
                    exp_byte = have_exp ? exp_q[0] : 8'h00;
                    exp_bits = '1;
                    exp_bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) exp_bits[i+1] = exp_byte[i];
`ifdef PARITY_EN
                    exp_bits[9] = ^exp_byte;
`endif
                    exp_bits[NB-1] = 1'b1;
                end
            end else begin
                rx_cnt++;
            end

            if (rx_active) begin
                if (line !== exp_bits[rx_cnt / BD]) shape_err++;
                if (rx_cnt % BD == BD / 2) sampled[rx_cnt / BD] = line;
                if (rx_cnt == FRAME - 1) begin
                    if (have_exp) begin
                        check("rx_byte", 32'(sampled[8:1]), 32'(exp_byte));
                        check("frame_shape", 32'(shape_err), 32'd0);
                        void'(exp_q.pop_front());
                    end
                    check("start_bit", 32'(sampled[0]), 32'd0);
                    check("stop_bit", 32'(sampled[NB-1]), 32'd1);
`ifdef PARITY_EN
                    check("even_parity", 32'(^sampled[9:1]), 32'd0);
`endif
                    rx_active = 1'b0;
                end
            end
            prev_line = line;
        end
    end

    initial begin
        int gap;
        int n;
        s_rst       = 1'b1;
        bus.tx_trig = 1'b0;
        bus.tx_data = 8'h00;

        // Reset held for 10 cycles: line high, not busy.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("reset_line", 32'(line), 32'd1);
            check("reset_busy", 32'(bus.tx_busy), 32'd0);
        end
        s_rst = 1'b0;
        tick();

        // Single frame.
        send(8'h55);

        // Trigger during a frame is dropped.
        send(8'hA3);
        repeat (40) tick();
        bus.tx_trig = 1'b1;
        bus.tx_data = 8'h32;
        tick();
        bus.tx_trig = 1'b0;
        check("ignored_trig_busy", 32'(bus.tx_busy), 32'd1);

        // Retrigger on the first idle cycle.
        send(8'h00);
        send(8'hFF);

        // Held trigger: back-to-back frames with one idle cycle between.
        wait_idle();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        bus.tx_trig = 1'b1;
        bus.tx_data = 8'h3C;
        tick();
        n = 0;
        while (bus.tx_busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        gap = 0;
        while (bus.tx_busy !== 1'b1 && gap < 100) begin
            gap++;
            tick();
        end
        bus.tx_trig = 1'b0;
        check("held_trig_gap", 32'(gap), 32'd1);

        // Reset mid-frame aborts, then a clean frame follows.
        send(8'h0F);
        repeat (70) tick();
        s_rst = 1'b1;
        tick();
        check("abort_line", 32'(line), 32'd1);
        check("abort_busy", 32'(bus.tx_busy), 32'd0);
        s_rst = 1'b0;
        tick();
        send(8'h81);

        // Reference receiver patterns.
        send(8'h00);
        send(8'hFF);
        send(8'h80);
        send(8'h01);

        n = 0;
        while ((exp_q.size() > 0 || rx_active || bus.tx_busy === 1'b1) && n < 2000) begin
            tick();
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
